// File: rtl/gfx_pixel_reader.sv
// Pixel fetch unit: converts a pixel coordinate into render-target (and optional
// z-buffer) word reads and extracts the big-endian pixel color / depth.
module gfx_pixel_reader #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:2]            target_base_i,
  input  logic [31:2]            zbuffer_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [point_width-1:0] target_size_y_i,
  input  logic [1:0]             color_depth_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic                   zbuffer_enable_i,
  input  logic                   read_i,
  output logic                   read_o,
  output logic [31:2]            read_addr_o,
  output logic [3:0]             read_sel_o,
  input  logic [31:0]            read_dat_i,
  input  logic                   read_ack_i,
  output logic [31:0]            color_o,
  output logic [point_width-1:0] depth_o,
  output logic                   oob_o,
  output logic                   ack_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_COLOR = 2'd1,
    ST_READ_DEPTH = 2'd2
  } state_t;

  // Byte offset (pix << bpp_shift) reduced to a word offset without a 32-bit temporary.
  function automatic logic [29:0] word_off(input logic [31:0] pix, input logic [1:0] cd);
    case (cd)
      2'b00:   word_off = pix[31:2];
      2'b01:   word_off = pix[30:1];
      default: word_off = pix[29:0];
    endcase
  endfunction

  function automatic logic [3:0] sel_for(input logic [1:0] cd, input logic [1:0] xl);
    case (cd)
      2'b00:   sel_for = 4'b1000 >> xl;
      2'b01:   sel_for = xl[0] ? 4'b0011 : 4'b1100;
      default: sel_for = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] dat, input logic [1:0] cd,
                                          input logic [1:0] xl);
    case (cd)
      2'b00: begin
        case (xl)
          2'd0:    extract = {24'd0, dat[31:24]};
          2'd1:    extract = {24'd0, dat[23:16]};
          2'd2:    extract = {24'd0, dat[15:8]};
          default: extract = {24'd0, dat[7:0]};
        endcase
      end
      2'b01:   extract = {16'd0, (xl[0] ? dat[15:0] : dat[31:16])};
      default: extract = dat;
    endcase
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [point_width-1:0] r_x;
  logic [point_width-1:0] r_y;
  logic [1:0]             r_cd;
  logic                   r_zen;
  logic                   r_read;
  logic [31:2]            r_read_addr;
  logic [3:0]             r_read_sel;
  logic [31:0]            r_color;
  logic [point_width-1:0] r_depth;
  logic                   r_oob;
  logic                   r_ack;
  logic                   r_busy;

  logic [point_width-1:0] w_px;
  logic [point_width-1:0] w_py;
  logic [31:0]            w_pix;
  logic [31:2]            w_color_addr;
  logic [31:2]            w_depth_addr;
  logic [15:0]            w_depth16;
  logic                   w_oob;
  logic                   w_ack_ok;
  logic                   w_issue_color;
  logic                   w_issue_depth;
  logic                   w_done_oob;
  logic                   w_cap_color;
  logic                   w_cap_depth;
  logic                   w_done;

  // Live coordinate while idle, latched coordinate while a depth address is formed.
  assign w_px         = (r_state == ST_IDLE) ? pixel_x_i : r_x;
  assign w_py         = (r_state == ST_IDLE) ? pixel_y_i : r_y;
  assign w_pix        = 32'(target_size_x_i) * 32'(w_py) + 32'(w_px);
  assign w_color_addr = target_base_i + word_off(w_pix, color_depth_i);
  assign w_depth_addr = zbuffer_base_i + word_off(w_pix, 2'b01);
  assign w_depth16    = r_x[0] ? read_dat_i[15:0] : read_dat_i[31:16];
  assign w_oob        = (pixel_x_i >= target_size_x_i) || (pixel_y_i >= target_size_y_i);
  // An ack coinciding with our own read strobe cannot belong to that read.
  assign w_ack_ok     = read_ack_i & ~r_read;

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_issue_color = 1'b0;
    w_issue_depth = 1'b0;
    w_done_oob    = 1'b0;
    w_cap_color   = 1'b0;
    w_cap_depth   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (read_i) begin
          if (w_oob) begin
            w_done_oob  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_issue_color = 1'b1;
            w_state_nxt   = ST_READ_COLOR;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ_COLOR: begin
        if (w_ack_ok) begin
          w_cap_color = 1'b1;
          if (r_zen) begin
            w_issue_depth = 1'b1;
            w_state_nxt   = ST_READ_DEPTH;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_READ_COLOR;
        end
      end
      ST_READ_DEPTH: begin
        if (w_ack_ok) begin
          w_cap_depth = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_READ_DEPTH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_done = w_done_oob | (w_cap_color & ~r_zen) | w_cap_depth;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request parameters captured on acceptance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_x   <= '0;
      r_y   <= '0;
      r_cd  <= 2'b00;
      r_zen <= 1'b0;
    end else if ((r_state == ST_IDLE) && read_i) begin
      r_x   <= pixel_x_i;
      r_y   <= pixel_y_i;
      r_cd  <= color_depth_i;
      r_zen <= zbuffer_enable_i;
    end
  end

  // Memory-side request outputs; address and select hold between requests.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_read      <= 1'b0;
      r_read_addr <= '0;
      r_read_sel  <= 4'b0000;
    end else begin
      r_read <= w_issue_color | w_issue_depth;
      if (w_issue_color) begin
        r_read_addr <= w_color_addr;
        r_read_sel  <= sel_for(color_depth_i, pixel_x_i[1:0]);
      end else if (w_issue_depth) begin
        r_read_addr <= w_depth_addr;
        r_read_sel  <= sel_for(2'b01, r_x[1:0]);
      end
    end
  end

  // Requester-side result outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_color <= 32'd0;
      r_depth <= '0;
      r_oob   <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack  <= w_done;
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_done_oob) begin
        r_color <= 32'd0;
        r_depth <= '1;
        r_oob   <= 1'b1;
      end else begin
        if (w_issue_color) r_oob   <= 1'b0;
        if (w_cap_color)   r_color <= extract(read_dat_i, r_cd, r_x[1:0]);
        if (w_cap_depth)   r_depth <= point_width'(w_depth16);
      end
    end
  end

  assign read_o      = r_read;
  assign read_addr_o = r_read_addr;
  assign read_sel_o  = r_read_sel;
  assign color_o     = r_color;
  assign depth_o     = r_depth;
  assign oob_o       = r_oob;
  assign ack_o       = r_ack;
  assign busy_o      = r_busy;

endmodule

// File: doc/gfx_pixel_reader.md
# gfx_pixel_reader

Pixel fetch unit for the GFX accelerator: given a pixel coordinate, it reads the render target word from video memory and extracts that pixel's color. When the z-buffer is enabled, it then reads the 16-bit depth value for the same pixel. It is the read-side counterpart of the pixel write path and sits between the rasterizer/blender (requester) and the wishbone master read port.

## Interface
- point_width, 16, width of coordinate and depth values
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- target_base_i  in  [31:2]  render target base word address
- zbuffer_base_i  in  [31:2]  z-buffer base word address
- target_size_x_i  in  point_width  target width in pixels
- target_size_y_i  in  point_width  target height in pixels
- color_depth_i  in  2  00=8 bpp, 01=16 bpp, 10/11=32 bpp
- pixel_x_i, pixel_y_i  in  point_width  coordinate, sampled on accepted request
- zbuffer_enable_i  in  1  also fetch depth; sampled on accepted request
- read_i  in  1  request strobe
- read_o  out  1  one-cycle read request to the wishbone master
- read_addr_o  out  [31:2]  read word address
- read_sel_o  out  4  byte selects of the read
- read_dat_i  in  32  read data, valid with read_ack_i
- read_ack_i  in  1  read complete
- color_o  out  32  extracted color, zero-extended
- depth_o  out  point_width  extracted depth
- oob_o  out  1  last request was out of bounds
- ack_o  out  1  one-cycle pulse: color_o/depth_o/oob_o valid
- busy_o  out  1  high in any state other than IDLE

## Operation
- States: IDLE, READ_COLOR, READ_DEPTH.
- IDLE with read_i: latch x, y, color_depth, and zbuffer_enable.
  - If x >= size_x or y >= size_y: stay IDLE, set color_o=0, depth_o=all ones, oob_o=1, pulse ack_o. No memory access.
  - Otherwise: set oob_o=0, pulse read_o with the color address, go to READ_COLOR.
- Color address:
  - offset_bytes = (size_x*y + x) << {0,1,2} for 8/16/32 bpp, computed in 32 bits with truncation.
  - address = target_base_i + offset_bytes[31:2].
- Depth address: zbuffer_base_i + ((size_x*y + x) << 1)[31:2]. The depth address always uses 16 bpp, independent of color_depth.
- read_sel_o:
  - 8 bpp: one-hot byte, big-endian (x[1:0]=0 selects bit 3).
  - 16 bpp: 1100 when x[0]=0, 0011 when x[0]=1.
  - 32 bpp: 1111.
  - Depth read: 16 bpp rule.
- Extraction, big-endian:
  - 8 bpp: x[1:0]=0 gives dat[31:24], 1 gives [23:16], 2 gives [15:8], 3 gives [7:0].
  - 16 bpp: x[0]=0 gives [31:16], x[0]=1 gives [15:0].
  - 32 bpp: whole word.
  - Depth: 16 bpp rule, zero-extended or truncated to point_width.
- READ_COLOR with read_ack_i: capture color_o.
  - If z enabled: pulse read_o with the depth address, go to READ_DEPTH.
  - Else: pulse ack_o, go to IDLE.
- READ_DEPTH with read_ack_i: capture depth_o, pulse ack_o, go to IDLE.
- depth_o is left unchanged on non-z in-bounds requests.
- read_i while busy is ignored and is not queued.
- read_ack_i in IDLE is ignored.
- color_o, depth_o, and oob_o hold their values until the next completion.

## Timing
- Reset values: read_o=0, read_addr_o=0, read_sel_o=0, color_o=0, depth_o=0, oob_o=0, ack_o=0, busy_o=0; state=IDLE.
- All outputs are registered.
- read_i at cycle N: read_o high at N+1, exactly one cycle. Address and select hold until the next request.
- read_ack_i is sampled from N+2 onward, i.e. from the cycle after read_o.
- Final read_ack_i at cycle M: ack_o high at M+1, and state is IDLE at M+1. A read_i in that cycle is accepted.
- Minimum latency, read_i to ack_o: 3 cycles without z, 5 cycles with z. Out of bounds: 1 cycle.
- read_ack_i in READ_COLOR with z enabled: second read_o at the next cycle.
- Reset asserted mid-operation: immediate return to the reset values and IDLE. A later read_ack_i produces no ack_o.

## Test plan
- 16 bpp read:
  - Stimulus: target_base=0x0400_0000, size 640x480, x=3, y=2, z off; read_dat_i=0xAAAA_1234 at the cycle after read_o.
  - Response: read_addr_o=0x0400_0281, sel=0011, color_o=0x0000_1234, ack_o 3 cycles after read_i.
- 8 bpp read:
  - Stimulus: x=5, y=0, dat=0x1122_3344.
  - Response: addr=base+1, sel=0100, color_o=0x0000_0022.
- 16 bpp with z:
  - Stimulus: 16 bpp, x=3, y=2, zbuffer_base=0x0800_0000; color dat=0xAAAA_1234, depth dat=0x5678_9ABC.
  - Response: second read_o with addr 0x0800_0281, sel 0011; depth_o=0x9ABC; ack_o 5 cycles after read_i with minimal ack delays.
- 32 bpp read:
  - Stimulus: x=1, y=1, dat=0xDEAD_BEEF.
  - Response: addr=base+0x281, sel=1111, color_o=0xDEAD_BEEF.
- Out of bounds:
  - Stimulus: x=640 (size_x=640).
  - Response: no read_o; ack_o at N+1; color_o=0, depth_o=0xFFFF, oob_o=1.
- Robustness:
  - Stimulus: read_i while busy; stray read_ack_i in IDLE; rst_i low while in READ_COLOR.
  - Response: read_i ignored; no ack_o; all outputs 0, busy_o=0, and a later read_ack_i is ignored.
